// File: rtl/lsu_rmw.sv
// ---------------------------------------------------------------------------
// lsu_rmw -- load/store unit with read-modify-write for sub-word stores
//
// Takes one RISC-V style load/store at a time from the core and performs it
// against a word-wide data memory that has combinational read data and a
// single-cycle write enable. Byte and half stores are turned into a
// read of the containing word, a lane merge and a full-word write.
//
// Handshake: a request is accepted on a rising clk edge where
// req_valid = 1 and req_ready = 1. req_ready is high only while idle. The
// request fields are captured at that edge, so later changes on the request
// ports have no effect. Completion is a single-cycle resp_valid pulse;
// resp_rdata and resp_err are valid with it and hold until the next pulse.
//
// Flow:
//   load         : IDLE -> READ -> RESP            (resp 2 cycles after accept)
//   SW           : IDLE -> WRITE -> RESP           (2 cycles)
//   SB / SH      : IDLE -> READ -> WRITE -> RESP   (3 cycles)
//   illegal      : IDLE -> RESP with resp_err      (1 cycle)
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  defined   : misaligned half/word accesses complete
//                                     as errors without touching memory.
//                         undefined : the offending low address bits are
//                                     cleared and the access proceeds.
//
// Ports:
//   clk, n_clr                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake
//   req_we, req_funct3         store flag, access size/sign
//   req_addr, req_wdata        byte address, right-aligned store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       extended load data, access error
//   mem_addr                   word-aligned memory address
//   mem_we, mem_wdata          memory write enable and merged word
//   mem_rdata                  combinational memory read data
//   dbg_state                  current FSM state (IDLE=0 READ=1 WRITE=2 RESP=3)
//   dbg_buf                    word buffer captured in READ
// ---------------------------------------------------------------------------
module lsu_rmw #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     n_clr,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic [1:0]               dbg_state,
  output logic [DATA_WIDTH-1:0]    dbg_buf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                   state;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    buf_q;

  // ---------------------------------------------------------------------
  // Request decode (only meaningful while idle)
  // ---------------------------------------------------------------------
  logic       acc_illegal;
  logic       acc_err;
  logic [1:0] eff_off;

  always_comb begin
    acc_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: acc_illegal = 1'b0;
      // Unsigned forms exist only for loads.
      3'b100, 3'b101:         acc_illegal = req_we;
      default:                acc_illegal = 1'b1;
    endcase
  end

  // Byte offset actually used for lane selection. Misaligned half/word
  // offsets are pulled down to the natural boundary; in the trapping build
  // those accesses never reach memory, so the cleared value is harmless.
  always_comb begin
    eff_off = req_addr[1:0];
    case (req_funct3[1:0])
      2'b01:   eff_off = {req_addr[1], 1'b0};
      2'b10:   eff_off = 2'b00;
      default: eff_off = req_addr[1:0];
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic acc_misaligned;

  always_comb begin
    acc_misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   acc_misaligned = req_addr[0];
      2'b10:   acc_misaligned = (req_addr[1:0] != 2'b00);
      default: acc_misaligned = 1'b0;
    endcase
  end

  assign acc_err = acc_illegal | acc_misaligned;
`else
  assign acc_err = acc_illegal;
`endif

  // ---------------------------------------------------------------------
  // Lane helpers
  // ---------------------------------------------------------------------

  // Replace the addressed lane(s) of word with the low bits of wdata.
  function automatic logic [DATA_WIDTH-1:0] merge_lane(
    input logic [DATA_WIDTH-1:0] word,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [1:0]            size,
    input logic [1:0]            off
  );
    logic [DATA_WIDTH-1:0] r;
    r = word;
    case (size)
      2'b00:   r[{off, 3'b000} +: 8]        = wdata[7:0];
      2'b01:   r[{off[1], 4'b0000} +: 16]   = wdata[15:0];
      default: r                            = wdata;
    endcase
    return r;
  endfunction

  // Move the addressed lane to bit 0 and sign- or zero-extend it.
  function automatic logic [DATA_WIDTH-1:0] extract_lane(
    input logic [DATA_WIDTH-1:0] word,
    input logic [2:0]            f3,
    input logic [1:0]            off
  );
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] r;
    lane = word >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{(DATA_WIDTH-8){lane[7]}},   lane[7:0]};
      3'b100:  r = {{(DATA_WIDTH-8){1'b0}},      lane[7:0]};
      3'b001:  r = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b101:  r = {{(DATA_WIDTH-16){1'b0}},     lane[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // FSM with registered outputs. Every output is set on the edge that
  // enters the state it belongs to, so resp_valid is high exactly in RESP,
  // mem_we exactly in WRITE and req_ready exactly in IDLE.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
    end else begin
      resp_valid <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            addr_q    <= {req_addr[ADDRESS_WIDTH-1:2], eff_off};
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (acc_err) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
              // Full-word store needs no read.
              state     <= S_WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state <= S_READ;
            end
          end
        end

        S_READ: begin
          buf_q <= mem_rdata;
          if (we_q) begin
            // mem_rdata is exactly what lands in the buffer this edge, so
            // the merge is taken from it directly.
            state     <= S_WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= merge_lane(mem_rdata, wdata_q, f3_q[1:0], addr_q[1:0]);
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= extract_lane(mem_rdata, f3_q, addr_q[1:0]);
          end
        end

        S_WRITE: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end

        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign mem_addr  = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
  assign dbg_state = state;
  assign dbg_buf   = buf_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// ---------------------------------------------------------------------------
// tb_lsu_rmw -- directed, table-driven bench for lsu_rmw.
// A small word memory sits behind the DUT; each vector optionally preloads a
// word, issues one request, then checks latency, response data/error, the
// number of write pulses and the resulting memory word.
// ---------------------------------------------------------------------------
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        n_clr;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_buf;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  lsu_rmw #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .n_clr      (n_clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state),
    .dbg_buf    (dbg_buf)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [16];
  int          we_cnt   = 0;
  int          resp_cnt = 0;

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[5:2]] = mem_wdata;
      we_cnt = we_cnt + 1;
    end
    if (resp_valid) resp_cnt = resp_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        pre;
    logic [3:0]  pre_idx;
    logic [31:0] pre_val;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wes;
    logic [3:0]  chk_idx;
    logic [31:0] exp_mem;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v);
    int   lat;
    int   we0;
    logic got;
    if (v.pre) mem[v.pre_idx] = v.pre_val;
    @(negedge clk);
    check({v.name, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    we0        = we_cnt;
    @(posedge clk);
    #1;
    // Scramble the ports: the accepted request must be unaffected.
    req_valid  = 1'b0;
    req_we     = ~v.we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5555_5555;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat = lat + 1;
      if (lat == 1) check({v.name, "_maddr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
      if (resp_valid) got = 1'b1;
    end
    if (!got) begin
      check({v.name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({v.name, "_lat"},   lat, v.exp_lat);
      check({v.name, "_rdata"}, resp_rdata, v.exp_rdata);
      check({v.name, "_err"},   {31'd0, resp_err}, {31'd0, v.exp_err});
    end
    check({v.name, "_wes"}, we_cnt - we0, v.exp_wes);
    check({v.name, "_mem"}, mem[v.chk_idx], v.exp_mem);
    @(negedge clk);
    check({v.name, "_pulse"}, {31'd0, resp_valid}, 32'd0);
    check({v.name, "_hold"},  resp_rdata, v.exp_rdata);
  endtask

  // ---------------- test ----------------
  initial begin : main
    int hs;
    int rc;
    int rc0;
    int we0;

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    //                name     pre  idx  pre_val        we  f3      addr   wdata          exp_rdata      err lat wes idx  exp_mem
    vecs[0]  = '{"sb9",     1'b1, 4'd2, 32'h1122_3344, 1'b1, 3'b000, 32'h08+1, 32'h0000_00AB, 32'h0,      1'b0, 3, 1, 4'd2, 32'h1122_AB44};
    vecs[1]  = '{"lb6",     1'b1, 4'd1, 32'h80FF_7F01, 1'b0, 3'b000, 32'h06, 32'h0,         32'hFFFF_FFFF, 1'b0, 2, 0, 4'd1, 32'h80FF_7F01};
    vecs[2]  = '{"lbu7",    1'b0, 4'd0, 32'h0,         1'b0, 3'b100, 32'h07, 32'h0,         32'h0000_0080, 1'b0, 2, 0, 4'd1, 32'h80FF_7F01};
    vecs[3]  = '{"lb5",     1'b0, 4'd0, 32'h0,         1'b0, 3'b000, 32'h05, 32'h0,         32'h0000_007F, 1'b0, 2, 0, 4'd1, 32'h80FF_7F01};
    vecs[4]  = '{"lw4",     1'b0, 4'd0, 32'h0,         1'b0, 3'b010, 32'h04, 32'h0,         32'h80FF_7F01, 1'b0, 2, 0, 4'd1, 32'h80FF_7F01};
    vecs[5]  = '{"lh6",     1'b0, 4'd0, 32'h0,         1'b0, 3'b001, 32'h06, 32'h0,         32'hFFFF_80FF, 1'b0, 2, 0, 4'd1, 32'h80FF_7F01};
    vecs[6]  = '{"lhu4",    1'b0, 4'd0, 32'h0,         1'b0, 3'b101, 32'h04, 32'h0,         32'h0000_7F01, 1'b0, 2, 0, 4'd1, 32'h80FF_7F01};
    vecs[7]  = '{"sh12",    1'b1, 4'd4, 32'h0,         1'b1, 3'b001, 32'h12, 32'h0000_BEEF, 32'h0,         1'b0, 3, 1, 4'd4, 32'hBEEF_0000};
    vecs[8]  = '{"lh12",    1'b0, 4'd0, 32'h0,         1'b0, 3'b001, 32'h12, 32'h0,         32'hFFFF_BEEF, 1'b0, 2, 0, 4'd4, 32'hBEEF_0000};
    vecs[9]  = '{"sw20",    1'b0, 4'd0, 32'h0,         1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1, 4'd8, 32'hDEAD_BEEF};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[10] = '{"lw6mis",  1'b0, 4'd0, 32'h0,         1'b0, 3'b010, 32'h06, 32'h0,         32'h0,         1'b1, 1, 0, 4'd1, 32'h80FF_7F01};
`else
    vecs[10] = '{"lw6mis",  1'b0, 4'd0, 32'h0,         1'b0, 3'b010, 32'h06, 32'h0,         32'h80FF_7F01, 1'b0, 2, 0, 4'd1, 32'h80FF_7F01};
`endif
    vecs[11] = '{"st_f100", 1'b0, 4'd0, 32'h0,         1'b1, 3'b100, 32'h08, 32'h0000_00CC, 32'h0,         1'b1, 1, 0, 4'd2, 32'h1122_AB44};
    vecs[12] = '{"ld_f011", 1'b0, 4'd0, 32'h0,         1'b0, 3'b011, 32'h04, 32'h0,         32'h0,         1'b1, 1, 0, 4'd1, 32'h80FF_7F01};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[13] = '{"sh13mis", 1'b0, 4'd0, 32'h0,         1'b1, 3'b001, 32'h13, 32'h0000_1234, 32'h0,         1'b1, 1, 0, 4'd4, 32'hBEEF_0000};
`else
    vecs[13] = '{"sh13mis", 1'b0, 4'd0, 32'h0,         1'b1, 3'b001, 32'h13, 32'h0000_1234, 32'h0,         1'b0, 3, 1, 4'd4, 32'h1234_0000};
`endif
    vecs[14] = '{"sb8",     1'b0, 4'd0, 32'h0,         1'b1, 3'b000, 32'h08, 32'hFFFF_FF5A, 32'h0,         1'b0, 3, 1, 4'd2, 32'h1122_AB5A};
    vecs[15] = '{"st_f110", 1'b0, 4'd0, 32'h0,         1'b1, 3'b110, 32'h20, 32'h0000_0011, 32'h0,         1'b1, 1, 0, 4'd8, 32'hDEAD_BEEF};

    // ---- reset state ----
    n_clr      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready},  32'd1);
    check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    check("rst_err",   {31'd0, resp_err},   32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_we",    {31'd0, mem_we},     32'd0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_maddr", mem_addr,  32'h0);
    check("rst_state", {30'd0, dbg_state},  32'd0);
    check("rst_buf",   dbg_buf,   32'h0);
    n_clr = 1'b1;
    @(negedge clk);

    // ---- table ----
    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // ---- held req_valid while busy: exactly one acceptance ----
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h04;
    hs  = 0;
    rc  = 0;
    for (int c = 0; c < 8; c++) begin
      if (resp_valid) begin
        rc = rc + 1;
        req_valid = 1'b0;
      end
      if (c > 0 && c < 3) check("busy_ready", {31'd0, req_ready}, 32'd0);
      if (req_valid && req_ready) hs = hs + 1;
      @(negedge clk);
    end
    check("busy_hs",    hs, 32'd1);
    check("busy_resp",  rc, 32'd1);
    check("busy_rdata", resp_rdata, 32'h80FF_7F01);
    check("busy_idle",  {31'd0, req_ready}, 32'd1);

    // ---- reset during WRITE of an SB ----
    mem[3] = 32'hCAFE_F00D;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h0D;
    req_wdata  = 32'h0000_0077;
    we0 = we_cnt;
    rc0 = resp_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);   // READ
    @(negedge clk);   // WRITE
    check("rw_in_write", {31'd0, mem_we}, 32'd1);
    n_clr = 1'b0;
    #1;
    check("rw_we_drop", {31'd0, mem_we}, 32'd0);
    check("rw_state",   {30'd0, dbg_state}, 32'd0);
    check("rw_ready",   {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    n_clr = 1'b1;
    repeat (4) @(negedge clk);
    check("rw_mem",    mem[3], 32'hCAFE_F00D);
    check("rw_wes",    we_cnt - we0, 32'd0);
    check("rw_noresp", resp_cnt - rc0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
